fdt_label_seq: RTL

//  Downstream of the NN unit: consumes per-frame NN decisions (dec_result/dec_result_vld).

---
 rtl/fdt_label_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fdt_label_seq.sv
// fdt_label_seq: debounces per-frame NN decisions into finger UP/DOWN levels.
// A shift register holds the last decisions; either the ones/zeros count in the
// window or the length of the current run of equal decisions is compared against
// separate enter-UP and enter-DOWN thresholds, giving hysteresis.
// Optional build macro FDT_LABEL_STAT_EN adds saturating UP/DOWN entry counters.
module fdt_label_seq #(
   parameter int MAX_SEQ = 16,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             soft_clr,
   input  logic             rg_label_seq_init_en,
   input  logic             rg_label_dec_mode,
   input  logic [4:0]       rg_label_up_memcnt_th,
   input  logic [4:0]       rg_label_dn_memcnt_th,
   input  logic [3:0]       rg_label_memseq_len,
   input  logic             dec_result,
   input  logic             dec_result_vld,
   output logic             ro_fdt_result_up,
   output logic             ro_fdt_result_down,
   output logic             fdt_evt,
   output logic [CNT_W-1:0] seq_ones
`ifdef FDT_LABEL_STAT_EN
   ,
   output logic [15:0]      ro_up_evt_cnt,
   output logic [15:0]      ro_dn_evt_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_UNK  = 2'd0,
      ST_DOWN = 2'd1,
      ST_UP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};

   state_t             state_q;
   logic [MAX_SEQ-1:0] seq_q, seq_d;
   logic [4:0]         fill_q, fill_d;
   logic [CNT_W-1:0]   run1_q, run1_d;
   logic [CNT_W-1:0]   run0_q, run0_d;
   logic [CNT_W-1:0]   seqOnes_q;
   logic               upLvl_q, dnLvl_q, evt_q;
   logic [4:0]         winLen, onesCnt, zerosCnt;
   logic               decideEn, upHit, dnHit, enterUp, enterDn;

   // Window length is the programmed length plus one, so 1..16 entries.
   assign winLen = {1'b0, rg_label_memseq_len} + 5'd1;

   // Next-sample datapath: shift, fill tracking, run counters, window popcount
   // and the threshold hits, all evaluated on the post-sample values so the
   // decision lands on the same edge that captures the decision.
   always_comb begin
      seq_d   = seq_q;
      fill_d  = fill_q;
      run1_d  = run1_q;
      run0_d  = run0_q;
      onesCnt = '0;
      if (dec_result_vld) begin
         seq_d  = {seq_q[MAX_SEQ-2:0], dec_result};
         fill_d = (fill_q >= winLen) ? winLen : fill_q + 5'd1;
         if (dec_result) begin
            run1_d = (run1_q == RUN_MAX) ? RUN_MAX : run1_q + 1'b1;
            run0_d = '0;
         end else begin
            run1_d = '0;
            run0_d = (run0_q == RUN_MAX) ? RUN_MAX : run0_q + 1'b1;
         end
      end
      for (int i = 0; i < MAX_SEQ; i++) begin
         if (i < int'(winLen)) begin
            onesCnt = onesCnt + {4'd0, seq_d[i]};
         end
      end
      zerosCnt = winLen - onesCnt;
      // Run mode always decides; count mode waits for a full window unless
      // the window is defined as pre-filled with zeros.
      decideEn = rg_label_dec_mode | rg_label_seq_init_en | (fill_d == winLen);
      if (rg_label_dec_mode) begin
         upHit = (rg_label_up_memcnt_th != 5'd0) && (run1_d >= CNT_W'(rg_label_up_memcnt_th));
         dnHit = (rg_label_dn_memcnt_th != 5'd0) && (run0_d >= CNT_W'(rg_label_dn_memcnt_th));
      end else begin
         upHit = (rg_label_up_memcnt_th != 5'd0) && (onesCnt >= rg_label_up_memcnt_th);
         dnHit = (rg_label_dn_memcnt_th != 5'd0) && (zerosCnt >= rg_label_dn_memcnt_th);
      end
      upHit   = upHit & dec_result_vld & decideEn;
      dnHit   = dnHit & dec_result_vld & decideEn;
      enterUp = upHit && (state_q != ST_UP);
      enterDn = dnHit && !enterUp && (state_q != ST_DOWN);
   end

   // Sample history, counters and the UNK/DOWN/UP state machine with its
   // registered level and change-event outputs; clear beats a coincident sample.
   always_ff @(posedge clk) begin
      if (!rstn || soft_clr) begin
         seq_q     <= '0;
         fill_q    <= '0;
         run1_q    <= '0;
         run0_q    <= '0;
         seqOnes_q <= '0;
         state_q   <= ST_UNK;
         upLvl_q   <= 1'b0;
         dnLvl_q   <= 1'b0;
         evt_q     <= 1'b0;
      end else begin
         seq_q  <= seq_d;
         fill_q <= fill_d;
         run1_q <= run1_d;
         run0_q <= run0_d;
         evt_q  <= 1'b0;
         if (dec_result_vld) begin
            seqOnes_q <= rg_label_dec_mode ? run1_d : CNT_W'(onesCnt);
         end
         if (enterUp) begin
            state_q <= ST_UP;
            upLvl_q <= 1'b1;
            dnLvl_q <= 1'b0;
            evt_q   <= 1'b1;
         end else if (enterDn) begin
            state_q <= ST_DOWN;
            upLvl_q <= 1'b0;
            dnLvl_q <= 1'b1;
            evt_q   <= 1'b1;
         end
      end
   end

   assign ro_fdt_result_up   = upLvl_q;
   assign ro_fdt_result_down = dnLvl_q;
   assign fdt_evt            = evt_q;
   assign seq_ones           = seqOnes_q;

`ifdef FDT_LABEL_STAT_EN
   logic [15:0] upEvtCnt_q, dnEvtCnt_q;

   // Saturating counts of entries into UP and into DOWN since the last clear.
   always_ff @(posedge clk) begin
      if (!rstn || soft_clr) begin
         upEvtCnt_q <= '0;
         dnEvtCnt_q <= '0;
      end else begin
         if (enterUp && (upEvtCnt_q != 16'hFFFF)) begin
            upEvtCnt_q <= upEvtCnt_q + 16'd1;
         end
         if (enterDn && (dnEvtCnt_q != 16'hFFFF)) begin
            dnEvtCnt_q <= dnEvtCnt_q + 16'd1;
         end
      end
   end

   assign ro_up_evt_cnt = upEvtCnt_q;
   assign ro_dn_evt_cnt = dnEvtCnt_q;
`endif

endmodule
